// File: rtl/scaler_pkg.sv
// Constants and types shared by the horizontal and vertical scalers.
package scaler_pkg;

  // Fraction bits of the 4.12 position/step format.
  localparam int FRAC_BITS = 12;

  // Clocks from an issued pixel to its appearance on the output stream.
  localparam int LAT = 3;

  typedef logic [15:0] step_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } hstate_t;

endpackage

// File: rtl/scaler_lerp.sv
// Two-tap rounding interpolator: o = (p0*(2^C-c) + p1*c + 2^(C-1)) >> C.
// Three register stages from i_valid to o_valid.
module scaler_lerp
  import scaler_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int COE_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_p0,
  input  logic [DATA_WIDTH-1:0] i_p1,
  input  logic [COE_WIDTH-1:0]  i_coe,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  // The weighted sum never exceeds (2^DW-1)*2^C + 2^(C-1), so DW+C bits hold it.
  localparam int SW   = DATA_WIDTH + COE_WIDTH;
  localparam int ONE  = 1 << COE_WIDTH;
  localparam int HALF = 1 << (COE_WIDTH - 1);

  logic                  r_v1, r_v2, r_v3;
  logic [DATA_WIDTH-1:0] r_p0, r_p1;
  logic [COE_WIDTH-1:0]  r_coe;
  logic [DATA_WIDTH-1:0] r_res;
  logic [DATA_WIDTH-1:0] r_do;
  logic [SW-1:0]         w_sum;
  logic [DATA_WIDTH-1:0] w_res;

  assign w_sum = SW'(r_p0) * (SW'(ONE) - SW'(r_coe)) + SW'(r_p1) * SW'(r_coe) + SW'(HALF);
  assign w_res = DATA_WIDTH'(w_sum >> COE_WIDTH);

  // Capture taps, compute the rounded blend, then register the result; data holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_v3  <= 1'b0;
      r_p0  <= '0;
      r_p1  <= '0;
      r_coe <= '0;
      r_res <= '0;
      r_do  <= '0;
    end else begin
      r_v1 <= i_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      if (i_valid) begin
        r_p0  <= i_p0;
        r_p1  <= i_p1;
        r_coe <= i_coe;
      end
      if (r_v1) r_res <= w_res;
      if (r_v2) r_do  <= r_res;
    end
  end

  assign o_valid = r_v3;
  assign o_data  = r_do;

endmodule

// File: rtl/scaler_h.sv
// Horizontal scaler: walks a 4.12 position across each input line and emits
// linearly interpolated pixels from the two most recent input pixels.
//
// state    | meaning
// ---------|---------------------------------------------------------------
// ST_IDLE  | waiting for a pixel pair that covers int(pos)
// ST_ISSUE | emitting outputs from the current pair, one per 1+SPARSE clks
module scaler_h
  import scaler_pkg::*;
#(
  parameter int SPARSE_OUTPUT = 0,
  parameter int COE_WIDTH     = 10,
  parameter int LINE_SIZE_MAX = 1024,
  parameter int LINE_STEP     = 4096,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  step_t                 scale_step,
  input  logic [15:0]           scale_line_size,
  input  logic [DATA_WIDTH-1:0] di_i,
  input  logic                  de_i,
  input  logic                  hs_i,
  input  logic                  vs_i,
  output logic [DATA_WIDTH-1:0] do_o,
  output logic                  de_o,
  output logic                  hs_o,
  output logic                  vs_o,
  output logic                  err_o
);

  localparam int IW = $clog2(LINE_SIZE_MAX) + 4;
  localparam int PW = IW + FRAC_BITS;
  localparam int NW = $clog2(LINE_SIZE_MAX) + 1;
  localparam int GW = (SPARSE_OUTPUT > 0) ? $clog2(SPARSE_OUTPUT + 1) : 1;

  hstate_t               r_state;
  step_t                 r_step;
  logic [15:0]           r_lsize;
  logic [PW-1:0]         r_pos;
  logic [NW-1:0]         r_n;
  logic [16:0]           r_k;
  logic [GW-1:0]         r_gap;
  logic [DATA_WIDTH-1:0] r_p0, r_p1;
  logic                  r_line_ok;
  logic                  r_err;
  logic [LAT-1:0]        r_hs_d, r_vs_d;

  step_t                 w_step;
  logic [IW-1:0]         w_pos_int, w_n_m2;
  logic [PW-1:0]         w_pos_nx;
  logic [16:0]           w_k_nx;
  logic                  w_pix, w_pair_ok, w_busy, w_issue, w_stay;
  logic [COE_WIDTH-1:0]  w_coe;
  logic                  w_lv;
  logic [DATA_WIDTH-1:0] w_ld;

  assign w_step    = (r_step == '0) ? step_t'(LINE_STEP) : r_step;
  assign w_pos_int = r_pos[PW-1:FRAC_BITS];
  assign w_n_m2    = {{(IW-NW){1'b0}}, r_n} - IW'(2);
  assign w_pos_nx  = r_pos + PW'(w_step);
  assign w_k_nx    = r_k + 17'd1;
  assign w_coe     = r_pos[FRAC_BITS-1 -: COE_WIDTH];

  // After a reset the rest of the current line is ignored until blanking re-syncs us.
  assign w_pix     = de_i && !hs_i && r_line_ok && (r_n < NW'(LINE_SIZE_MAX));
  assign w_pair_ok = (r_n >= NW'(2)) && (w_pos_int == w_n_m2) && (r_k <= {1'b0, r_lsize});
  // A pixel landing while the current pair still owes outputs is an overrun.
  assign w_busy    = (r_state == ST_ISSUE) || w_pair_ok;
  assign w_issue   = (r_state == ST_ISSUE) && (r_gap == '0) && !hs_i && !w_pix;
  assign w_stay    = (w_pos_nx[PW-1:FRAC_BITS] == w_n_m2) && (w_k_nx <= {1'b0, r_lsize});

  // Line control FSM: blanking restart, pixel shift-in, issue pacing and overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_step    <= '0;
      r_lsize   <= '0;
      r_pos     <= '0;
      r_n       <= '0;
      r_k       <= '0;
      r_gap     <= '0;
      r_p0      <= '0;
      r_p1      <= '0;
      r_line_ok <= 1'b0;
      r_err     <= 1'b0;
    end else if (hs_i) begin
      r_step    <= scale_step;
      r_lsize   <= scale_line_size;
      r_pos     <= '0;
      r_n       <= '0;
      r_k       <= '0;
      r_gap     <= '0;
      r_state   <= ST_IDLE;
      r_line_ok <= 1'b1;
    end else if (w_pix) begin
      r_p0    <= r_p1;
      r_p1    <= di_i;
      r_n     <= r_n + NW'(1);
      r_gap   <= '0;
      r_state <= ST_IDLE;
      if (w_busy) r_err <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pair_ok) begin
            r_state <= ST_ISSUE;
            r_gap   <= '0;
          end
        end
        ST_ISSUE: begin
          if (r_gap != '0) begin
            r_gap <= r_gap - GW'(1);
          end else begin
            r_pos <= w_pos_nx;
            r_k   <= w_k_nx;
            r_gap <= GW'(SPARSE_OUTPUT);
            if (!w_stay) r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Sync delay matching the interpolator latency; reset fills it with blanking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hs_d <= '1;
      r_vs_d <= '1;
    end else begin
      r_hs_d <= {r_hs_d[LAT-2:0], hs_i};
      r_vs_d <= {r_vs_d[LAT-2:0], vs_i};
    end
  end

  scaler_lerp #(
    .DATA_WIDTH (DATA_WIDTH),
    .COE_WIDTH  (COE_WIDTH)
  ) u_lerp (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_issue),
    .i_p0    (r_p0),
    .i_p1    (r_p1),
    .i_coe   (w_coe),
    .o_valid (w_lv),
    .o_data  (w_ld)
  );

  assign hs_o  = r_hs_d[LAT-1];
  assign vs_o  = r_vs_d[LAT-1];
  assign de_o  = w_lv & ~hs_o;
  assign do_o  = w_ld;
  assign err_o = r_err;

endmodule

// File: doc/scaler_h.md
SCALER_H -- requirements
Module: scaler_h

Interface
REQ-001 SHALL have parameter SPARSE_OUTPUT, default 0, meaning the number of idle cycles inserted between issued output pixels.
REQ-002 SHALL have parameter COE_WIDTH, default 10, meaning the interpolation coefficient width.
REQ-003 SHALL have parameter LINE_SIZE_MAX, default 1024, meaning the maximum number of input pixels per line.
REQ-004 SHALL have parameter LINE_STEP, default 4096, meaning the 1.000 scale value in 4.12 fixed point.
REQ-005 SHALL have parameter DATA_WIDTH, default 8, meaning the pixel width.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port scale_step, input, 16 bits: input pixels per output pixel, 4.12 unsigned (2048 = 2x upscale, 8192 = 2x downscale).
REQ-009 SHALL have port scale_line_size, input, 16 bits: maximum output pixels per line, minus 1.
REQ-010 SHALL have ports di_i (DATA_WIDTH bits), de_i, hs_i and vs_i (1 bit each), all inputs: the input video stream; hs_i/vs_i are high during blanking.
REQ-011 SHALL have ports do_o (DATA_WIDTH bits), de_o, hs_o and vs_o (1 bit each), all outputs: the output stream, which feeds scaler_v.
REQ-012 SHALL have port err_o, output, 1 bit: sticky overrun flag.

Function
REQ-013 SHALL latch scale_step and scale_line_size on every clk where hs_i=1, and SHALL hold them constant while hs_i=0.
REQ-014 SHALL treat a latched scale_step of 0 as LINE_STEP.
REQ-015 SHALL keep a position accumulator pos (12 fraction bits, clog2(LINE_SIZE_MAX)+4 integer bits), an input-pixel counter n, and an output counter k.
REQ-016 SHALL clear pos, n, k and any pending issue, and go to IDLE, on every clk where hs_i=1.
REQ-017 SHALL shift the registers on each de_i=1 with hs_i=0 as p0<=p1, p1<=di_i, n<=n+1.
REQ-018 SHALL, after the pixel-arrival update of REQ-017, enter ISSUE on the next clk when n>=2 and int(pos)==n-2 and k<=scale_line_size; otherwise it SHALL stay in IDLE.
REQ-019 SHALL, in ISSUE, issue one output per 1+SPARSE_OUTPUT clks, with pos+=step and k+=1 per issue.
REQ-020 SHALL return from ISSUE to IDLE when int(pos) no longer equals n-2 or k exceeds scale_line_size.
REQ-021 SHALL skip input pixels without issuing when step>4096 leaves int(pos)>n-2.
REQ-022 SHALL compute each issued pixel as do=(p0*(2^C-c)+p1*c+2^(C-1))>>C, where C=COE_WIDTH and c=pos[11:12-C].
REQ-023 SHALL produce a result within 0..2^DATA_WIDTH-1 without saturation logic.
REQ-024 SHALL present each issued pixel on do_o/de_o exactly LAT=3 clks after issue.
REQ-025 SHALL drive hs_o/vs_o as hs_i/vs_i delayed by LAT.
REQ-026 SHALL hold de_o=0 whenever hs_o=1.
REQ-027 SHALL hold do_o at its last value when de_o=0.
REQ-028 SHALL, when de_i=1 arrives while in ISSUE, set err_o=1, drop the remaining issues for the old pixel pair, and process the new pixel normally.
REQ-029 SHALL clear err_o only on rst.
REQ-030 SHALL never issue outputs that need the pixel after the last pixel of the line, so identity scaling of W pixels yields W-1 outputs.
REQ-031 SHALL ignore de_i pixels beyond LINE_SIZE_MAX, with n saturating.

Reset
REQ-032 SHALL, on rst=1 at clk, set do_o=0, de_o=0, hs_o=1, vs_o=1, err_o=0, the state to IDLE, pos/n/k/p0/p1=0, and all delay-pipe entries to blanking.
REQ-033 SHALL let rst mid-line abort all pending issues, with no de_o produced until the next line with hs_i=0.

Structure
REQ-034 SHALL take from shared package scaler_pkg: the fraction-bit count (12), LAT, and the 16-bit step type, which scaler_v also uses.
REQ-035 SHALL place the 2-tap rounding multiply-add pipeline (LAT stages, with data valid in and out) in sub-module scaler_lerp.

Verification
REQ-036 SHALL verify identity: step=4096, 25-pixel ramp x*10, DE period 4 -> 24 outputs 0,10,...,230; err_o=0.
REQ-037 SHALL verify 2x upscale: step=2048, input 0,100,200, DE period 4 -> outputs 0,50,100,150.
REQ-038 SHALL verify 2x downscale: step=8192, 25-pixel ramp x*10 -> 12 outputs 0,20,...,220, with hs_o aligned to hs_i+3.
REQ-039 SHALL verify limit and rounding: scale_line_size=4 with step=4096 -> exactly 5 outputs; p0=0, p1=255, c=512 -> 128.
REQ-040 SHALL verify overrun: step=2048 with DE period 0 (back-to-back) -> err_o=1 after the third pixel and stays 1 until rst.
REQ-041 SHALL verify reset mid-line: rst pulse at pixel 10 -> de_o=0, hs_o=1, vs_o=1 next clk; the next line is output correctly.
